fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register with stall/flush and halt freeze.
// Build option: define FETCH_PERF_CNT_EN to add the fetched/stall/flush performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] cnt_fetched,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        halt_detect;

    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign halt_detect = if_id_valid && (if_id_inst[31:26] == 6'b111111);

    always_comb begin
        case (pcsrc)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jump_target;
            default: next_pc = jr_target;
        endcase
    end

    // Stall outranks halt detection so a stalled halt instruction is re-evaluated later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            state       <= RUN;
            halted      <= 1'b0;
        end else if (state == RUN && !stall) begin
            if (halt_detect) begin
                state       <= HALTED;
                halted      <= 1'b1;
                if_id_inst  <= NOP_INST;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
            end else if (flush) begin
                pc          <= next_pc;
                if_id_inst  <= NOP_INST;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
            end else begin
                pc          <= next_pc;
                if_id_inst  <= imem_inst;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_fetched <= 32'd0;
            cnt_stall   <= 32'd0;
            cnt_flush   <= 32'd0;
        end else if (state == RUN) begin
            if (stall) begin
                cnt_stall <= cnt_stall + 32'd1;
            end else if (!halt_detect) begin
                if (flush) begin
                    cnt_flush <= cnt_flush + 32'd1;
                end else begin
                    cnt_fetched <= cnt_fetched + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes reference-model expectations, monitor pops and compares after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [1:0]  pcsrc;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] imem_inst, imem_addr, if_id_inst, if_id_pc4;
    logic        if_id_valid, halted;
    logic [31:0] imem_inst2, imem_addr2, if_id_inst2, if_id_pc4_2;
    logic        if_id_valid2, halted2;
    logic [31:0] halt_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_fetched, cnt_stall, cnt_flush;
    logic [31:0] cnt_fetched2, cnt_stall2, cnt_flush2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 ^ a;
    endfunction

    assign imem_inst  = (imem_addr == halt_addr) ? 32'hFC00_0000 : word_at(imem_addr);
    assign imem_inst2 = word_at(imem_addr2);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
        .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
        .imem_inst(imem_inst), .imem_addr(imem_addr), .if_id_inst(if_id_inst),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .cnt_fetched(cnt_fetched), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .pcsrc(2'b00),
        .branch_target(32'd0), .jump_target(32'd0), .jr_target(32'd0),
        .imem_inst(imem_inst2), .imem_addr(imem_addr2), .if_id_inst(if_id_inst2),
        .if_id_pc4(if_id_pc4_2), .if_id_valid(if_id_valid2), .halted(halted2)
`ifdef FETCH_PERF_CNT_EN
        , .cnt_fetched(cnt_fetched2), .cnt_stall(cnt_stall2), .cnt_flush(cnt_flush2)
`endif
    );

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_inst, m_pc4, m_fe, m_st, m_fl;
    logic        m_valid, m_halt;

    typedef struct {
        logic [31:0] addr, inst, pc4, fe, st, fl;
        logic        valid, halted;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return (a == halt_addr) ? 32'hFC00_0000 : word_at(a);
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_inst = 32'd0; m_pc4 = 32'd0;
        m_valid = 1'b0; m_halt = 1'b0;
        m_fe = 32'd0; m_st = 32'd0; m_fl = 32'd0;
    endtask

    task automatic model_step(input bit s, input bit f, input logic [1:0] ps,
                              input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        logic [31:0] tgt;
        if (m_halt) return;
        if (s) begin
            m_st = m_st + 32'd1;
            return;
        end
        if (m_valid && m_inst[31:26] == 6'b111111) begin
            m_halt = 1'b1; m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            return;
        end
        case (ps)
            2'd0:    tgt = m_pc + 32'd4;
            2'd1:    tgt = bt;
            2'd2:    tgt = jt;
            default: tgt = jrt;
        endcase
        if (f) begin
            m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_fl = m_fl + 32'd1;
        end else begin
            m_inst = mem_at(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_fe = m_fe + 32'd1;
        end
        m_pc = tgt;
    endtask

    task automatic push_exp();
        exp_t e;
        e.addr = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.halted = m_halt;
        e.fe = m_fe; e.st = m_st; e.fl = m_fl;
        q.push_back(e);
    endtask

    task automatic cyc(input bit s, input bit f, input logic [1:0] ps,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        @(negedge clk);
        rst = 1'b1; stall = s; flush = f; pcsrc = ps;
        branch_target = bt; jump_target = jt; jr_target = jrt;
        model_step(s, f, ps, bt, jt, jrt);
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
        #1;
        model_reset();
        check("reset imem_addr", imem_addr, 32'h0000_0000);
        check("reset if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("reset if_id_inst", if_id_inst, 32'h0000_0000);
        check("reset if_id_pc4", if_id_pc4, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        check("reset wrap imem_addr", imem_addr2, 32'hFFFF_FFFC);
        push_exp();
    endtask

    function automatic logic [31:0] rand_tgt();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'(4 * $urandom_range(0, 255));
    endfunction

    // Monitor: one expectation per rising edge once the driver has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("imem_addr", imem_addr, e.addr);
                check("if_id_inst", if_id_inst, e.inst);
                check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                check("halted", {31'd0, halted}, {31'd0, e.halted});
                if (!e.halted) check("if_id_pc4", if_id_pc4, e.pc4);
`ifdef FETCH_PERF_CNT_EN
                check("cnt_fetched", cnt_fetched, e.fe);
                check("cnt_stall", cnt_stall, e.st);
                check("cnt_flush", cnt_flush, e.fl);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
        branch_target = 32'd0; jump_target = 32'd0; jr_target = 32'd0;
        halt_addr = 32'hFFFF_FFFF;

        // Free run from reset, plus the wrap-around instance.
        do_reset();
        cyc(0, 0, 2'b00, 0, 0, 0);
        @(posedge clk);
        #2;
        check("wrap imem_addr", imem_addr2, 32'h0000_0000);
        check("wrap if_id_pc4", if_id_pc4_2, 32'h0000_0000);
        check("wrap if_id_inst", if_id_inst2, word_at(32'hFFFF_FFFC));
        check("wrap if_id_valid", {31'd0, if_id_valid2}, 32'd1);
        cyc(0, 0, 2'b00, 0, 0, 0);
        // Stall at pc=8 with a branch select that must be ignored.
        cyc(1, 0, 2'b01, 32'h40, 0, 0);
        cyc(1, 1, 2'b01, 32'h40, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        // Redirects with one bubble each.
        cyc(0, 1, 2'b01, 32'h40, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(0, 1, 2'b11, 0, 0, 32'h200);
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(0, 1, 2'b10, 0, 32'h100, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        // Halt at 0x14; a flush on the detect cycle must lose.
        halt_addr = 32'h14;
        cyc(0, 1, 2'b01, 32'h14, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 0);
        cyc(0, 1, 2'b01, 32'h40, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(i[0], i[1], 2'(i), 32'h80, 32'h90, 32'hA0);
        do_reset();
        cyc(0, 0, 2'b00, 0, 0, 0);

        // Randomized episodes with occasional mid-run resets.
        for (int ep = 0; ep < 6; ep++) begin
            halt_addr = 32'(4 * $urandom_range(0, 255));
            do_reset();
            for (int i = 0; i < 160; i++) begin
                if ($urandom_range(0, 79) == 0)
                    do_reset();
                else
                    cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                        2'($urandom_range(0, 3)), rand_tgt(), rand_tgt(), rand_tgt());
            end
        end

        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
